// File: rtl/player_move_ctrl.sv
// rtl/player_move_ctrl.sv - runner lane / jump / slide movement controller
// Turns debounced button pulses into lane, move state and jump height, paced by the frame tick.
module player_move_ctrl #(
   parameter int NUM_LANES   = 3,
   parameter int JUMP_TICKS  = 16,
   parameter int SLIDE_TICKS = 12,
   parameter int CNT_W       = 8
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_game_active,
   input  logic             i_game_tick,
   input  logic             i_btn_left,
   input  logic             i_btn_right,
   input  logic             i_btn_up,
   input  logic             i_btn_down,
   output logic [1:0]       o_lane,
   output logic [1:0]       o_move_state,
   output logic [CNT_W-1:0] o_jump_height,
   output logic             o_pending,
   output logic             o_action_done
);

   typedef enum logic [1:0] {
      ST_RUN   = 2'b00,
      ST_JUMP  = 2'b01,
      ST_SLIDE = 2'b10
   } state_t;

   localparam logic [1:0]       LANE_CENTRE = 2'(NUM_LANES / 2);
   localparam logic [1:0]       LANE_MAX    = 2'(NUM_LANES - 1);
   localparam logic [CNT_W-1:0] JUMP_LIM    = CNT_W'(JUMP_TICKS);
   localparam logic [CNT_W-1:0] SLIDE_LIM   = CNT_W'(SLIDE_TICKS);
   localparam logic [CNT_W-1:0] JUMP_HALF   = CNT_W'(JUMP_TICKS / 2);

   state_t           r_state, r_pend_act;
   logic [CNT_W-1:0] r_cnt, r_height;
   logic [1:0]       r_lane;
   logic             r_pend, r_done;

   state_t           w_state, w_pend_act, w_req_act;
   logic [CNT_W-1:0] w_cnt, w_height, w_cnt_inc, w_limit;
   logic [1:0]       w_lane;
   logic             w_pend, w_done, w_req;

   assign w_req     = i_btn_up | i_btn_down;
   assign w_req_act = i_btn_up ? ST_JUMP : ST_SLIDE;
   assign w_cnt_inc = r_cnt + 1'b1;
   assign w_limit   = (r_state == ST_JUMP) ? JUMP_LIM : SLIDE_LIM;

   always_comb begin
      w_lane     = r_lane;
      w_state    = r_state;
      w_cnt      = r_cnt;
      w_pend     = r_pend;
      w_pend_act = r_pend_act;
      w_done     = 1'b0;
      w_height   = '0;
      if (!i_game_active) begin
         w_lane  = LANE_CENTRE;
         w_state = ST_RUN;
         w_cnt   = '0;
         w_pend  = 1'b0;
      end else begin
         if (i_btn_left && !i_btn_right && r_lane != 2'd0)
            w_lane = r_lane - 2'd1;
         else if (i_btn_right && !i_btn_left && r_lane != LANE_MAX)
            w_lane = r_lane + 2'd1;

         if (r_state == ST_RUN) begin
            if (w_req) begin
               w_state = w_req_act;
               w_cnt   = '0;
            end
         end else if (i_game_tick && w_cnt_inc == w_limit) begin
            // A request on the ending tick supersedes anything buffered.
            w_done = 1'b1;
            w_cnt  = '0;
            w_pend = 1'b0;
            if (w_req)
               w_state = w_req_act;
            else if (r_pend)
               w_state = r_pend_act;
            else
               w_state = ST_RUN;
         end else begin
            if (i_game_tick)
               w_cnt = w_cnt_inc;
            if (w_req) begin
               w_pend     = 1'b1;
               w_pend_act = w_req_act;
            end
         end
      end

      if (w_state == ST_JUMP)
         w_height = (w_cnt <= JUMP_HALF) ? w_cnt : (JUMP_LIM - w_cnt);
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state    <= ST_RUN;
         r_pend_act <= ST_RUN;
         r_cnt      <= '0;
         r_height   <= '0;
         r_lane     <= LANE_CENTRE;
         r_pend     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_state    <= w_state;
         r_pend_act <= w_pend_act;
         r_cnt      <= w_cnt;
         r_height   <= w_height;
         r_lane     <= w_lane;
         r_pend     <= w_pend;
         r_done     <= w_done;
      end
   end

   assign o_lane        = r_lane;
   assign o_move_state  = r_state;
   assign o_jump_height = r_height;
   assign o_pending     = r_pend;
   assign o_action_done = r_done;

endmodule

// File: tb/tb_player_move_ctrl.sv
// tb/tb_player_move_ctrl.sv - bench for player_move_ctrl
// Vector table, hand sequences for multi-cycle corners, and random traffic against a model.
module tb_player_move_ctrl;

   localparam int NL = 3;
   localparam int JT = 16;
   localparam int ST = 12;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          active = 1'b1;
   logic          tick = 1'b0;
   logic          bl = 1'b0, br = 1'b0, bu = 1'b0, bd = 1'b0;
   logic [1:0]    lane, mstate;
   logic [CW-1:0] height;
   logic          pend, done;

   int total = 0;
   int bad   = 0;

   // Model: mode 0 run / 1 jump / 2 slide, elapsed ticks, buffered action (0 = none).
   int m_lane, m_mode, m_elapsed, m_buf, m_done;

   player_move_ctrl #(.NUM_LANES(NL), .JUMP_TICKS(JT), .SLIDE_TICKS(ST), .CNT_W(CW)) dut (
      .i_clk(clk), .i_reset(rst_n), .i_game_active(active), .i_game_tick(tick),
      .i_btn_left(bl), .i_btn_right(br), .i_btn_up(bu), .i_btn_down(bd),
      .o_lane(lane), .o_move_state(mstate), .o_jump_height(height),
      .o_pending(pend), .o_action_done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int exp_height();
      if (m_mode != 1) return 0;
      return (m_elapsed <= JT / 2) ? m_elapsed : JT - m_elapsed;
   endfunction

   task automatic model_reset();
      m_lane = NL / 2; m_mode = 0; m_elapsed = 0; m_buf = 0; m_done = 0;
   endtask

   task automatic model_step(input bit l, input bit r, input bit u, input bit d,
                             input bit t, input bit a);
      int req;
      m_done = 0;
      if (!a) begin
         m_lane = NL / 2; m_mode = 0; m_elapsed = 0; m_buf = 0;
         return;
      end
      if (l && !r) m_lane = (m_lane > 0) ? m_lane - 1 : 0;
      if (r && !l) m_lane = (m_lane < NL - 1) ? m_lane + 1 : NL - 1;
      req = u ? 1 : (d ? 2 : 0);
      if (m_mode == 0) begin
         if (req != 0) begin m_mode = req; m_elapsed = 0; end
      end else begin
         if (t) m_elapsed++;
         if (t && m_elapsed == ((m_mode == 1) ? JT : ST)) begin
            m_done = 1;
            m_elapsed = 0;
            m_mode = (req != 0) ? req : m_buf;
            m_buf = 0;
         end else if (req != 0) begin
            m_buf = req;
         end
      end
   endtask

   task automatic check_model();
      chk("model_lane", lane, m_lane);
      chk("model_state", mstate, m_mode);
      chk("model_height", height, exp_height());
      chk("model_pending", pend, (m_buf != 0) ? 1 : 0);
      chk("model_done", done, m_done);
   endtask

   // Inputs change on the falling edge; outputs are sampled on the next falling edge.
   task automatic cycle(input bit l, input bit r, input bit u, input bit d,
                        input bit t, input bit a);
      bl = l; br = r; bu = u; bd = d; tick = t; active = a;
      @(posedge clk);
      model_step(l, r, u, d, t, a);
      @(negedge clk);
      bl = 0; br = 0; bu = 0; bd = 0; tick = 0; active = 1;
      check_model();
   endtask

   task automatic do_reset();
      rst_n = 0;
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1;
      @(negedge clk);
   endtask

   task automatic chk_all(input string name, input int l, input int s, input int h,
                          input int p, input int d);
      chk({name, "_lane"}, lane, l);
      chk({name, "_state"}, mstate, s);
      chk({name, "_height"}, height, h);
      chk({name, "_pend"}, pend, p);
      chk({name, "_done"}, done, d);
   endtask

   typedef struct {
      bit l, r, u, d, t;
      int e_lane, e_state, e_height, e_pend, e_done;
   } vec_t;

   vec_t vt[13];

   initial begin
      vt[0]  = '{0, 1, 0, 0, 0, 2, 0, 0, 0, 0};
      vt[1]  = '{0, 1, 0, 0, 0, 2, 0, 0, 0, 0};
      vt[2]  = '{0, 1, 0, 0, 0, 2, 0, 0, 0, 0};
      vt[3]  = '{1, 0, 0, 0, 0, 1, 0, 0, 0, 0};
      vt[4]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      vt[5]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      vt[6]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      vt[7]  = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
      vt[8]  = '{0, 1, 0, 0, 0, 1, 0, 0, 0, 0};
      vt[9]  = '{0, 0, 1, 1, 0, 1, 1, 0, 0, 0};
      vt[10] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
      vt[11] = '{0, 0, 0, 1, 0, 1, 1, 1, 1, 0};
      vt[12] = '{1, 1, 0, 0, 1, 1, 1, 2, 1, 0};

      model_reset();
      repeat (2) @(negedge clk);
      chk_all("reset", 1, 0, 0, 0, 0);
      rst_n = 1;
      @(negedge clk);

      for (int i = 0; i < 13; i++) begin
         cycle(vt[i].l, vt[i].r, vt[i].u, vt[i].d, vt[i].t, 1);
         chk_all($sformatf("vec%0d", i), vt[i].e_lane, vt[i].e_state,
                 vt[i].e_height, vt[i].e_pend, vt[i].e_done);
      end

      // Full jump profile
      do_reset();
      cycle(0, 0, 1, 0, 0, 1);
      chk("jump_enter", mstate, 1);
      for (int k = 1; k < JT; k++) begin
         cycle(0, 0, 0, 0, 1, 1);
         chk($sformatf("jump_h%0d", k), height, (k <= JT / 2) ? k : JT - k);
      end
      cycle(0, 0, 0, 0, 1, 1);
      chk_all("jump_end", 1, 0, 0, 0, 1);
      cycle(0, 0, 0, 0, 0, 1);
      chk("jump_done_clr", done, 0);

      // Buffered slide chained after jump with no RUN cycle
      do_reset();
      cycle(0, 0, 1, 0, 0, 1);
      repeat (5) cycle(0, 0, 0, 0, 1, 1);
      cycle(0, 0, 0, 1, 0, 1);
      cycle(0, 0, 0, 1, 0, 1);
      chk("buf_pend", pend, 1);
      repeat (10) cycle(0, 0, 0, 0, 1, 1);
      chk("buf_still_jump", mstate, 1);
      cycle(0, 0, 0, 0, 1, 1);
      chk_all("buf_chain", 1, 2, 0, 0, 1);
      repeat (11) cycle(0, 0, 0, 0, 1, 1);
      chk("slide_not_done", done, 0);
      cycle(0, 0, 0, 0, 1, 1);
      chk_all("slide_end", 1, 0, 0, 0, 1);

      // Tick coincident with the accepted request is not counted
      do_reset();
      cycle(0, 0, 1, 0, 1, 1);
      chk_all("coinc_enter", 1, 1, 0, 0, 0);
      repeat (15) cycle(0, 0, 0, 0, 1, 1);
      chk("coinc_15", mstate, 1);
      chk("coinc_h15", height, 1);
      cycle(0, 0, 0, 0, 1, 1);
      chk_all("coinc_end", 1, 0, 0, 0, 1);

      // game_active drop mid-slide
      do_reset();
      cycle(0, 0, 0, 1, 0, 1);
      repeat (3) cycle(0, 0, 0, 0, 1, 1);
      cycle(0, 0, 1, 0, 0, 1);
      cycle(0, 1, 0, 0, 0, 1);
      chk("inact_pre_lane", lane, 2);
      chk("inact_pre_pend", pend, 1);
      cycle(0, 1, 1, 0, 1, 0);
      chk_all("inactive", 1, 0, 0, 0, 0);

      // Asynchronous reset mid-jump
      cycle(0, 0, 1, 0, 0, 1);
      repeat (3) cycle(0, 0, 0, 0, 1, 1);
      cycle(0, 0, 0, 1, 0, 1);
      cycle(1, 0, 0, 0, 0, 1);
      chk("areset_pre_h", height, 3);
      #2 rst_n = 0;
      model_reset();
      #1 chk_all("areset", 1, 0, 0, 0, 0);
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);

      for (int n = 0; n < 3000; n++) begin
         cycle(($urandom % 6) == 0, ($urandom % 6) == 0, ($urandom % 10) == 0,
               ($urandom % 10) == 0, ($urandom % 3) == 0, ($urandom % 80) != 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
